// File: rtl/chart_judge_sequencer_pkg.sv
// Shared types, constants and helpers for the chart judge sequencer.
// Chart ROM word layout, LSB first: time[TIME_W-1:0], lane[1:0], end.
package chart_judge_sequencer_pkg;

    typedef enum logic [1:0] {
        MISS    = 2'd0,
        GOOD    = 2'd1,
        PERFECT = 2'd2
    } judge_result_e;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam logic [31:0] SCORE_PERFECT = 32'd300;
    localparam logic [31:0] SCORE_GOOD    = 32'd100;

    localparam int TIME_LSB = 0;

    function automatic int lane_lsb(input int time_w);
        return time_w;
    endfunction

    function automatic int end_bit(input int time_w);
        return time_w + 2;
    endfunction

    // Returns {found, lane}: first requesting lane, scanning upward from the one after last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (req[idx] && !pick[2]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/chart_judge_sequencer_lane_queue.sv
// Per-lane circular FIFO of pending note times.
// A push into a full queue is accepted when a pop happens in the same cycle.
module lane_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = next_ptr(wr_q);
        end
        if (do_pop) begin
            rd_d = next_ptr(rd_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chart_judge_sequencer.sv
// Plays one song chart against a millisecond clock, queues notes per lane and
// judges key presses into score, combo and one-cycle judgement strobes.
module chart_judge_sequencer
    import chart_judge_sequencer_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int ADDR_W     = 10,
    parameter int TIME_W     = 20,
    parameter int PERFECT_MS = 40,
    parameter int GOOD_MS    = 100,
    parameter int MISS_MS    = 150,
    parameter int QDEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   chart_base,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [TIME_W+2:0]   rom_data,
    input  logic [3:0]          key_press,
    output logic [TIME_W-1:0]   song_time,
    output logic [31:0]         score,
    output logic [15:0]         combo,
    output logic                judge_valid,
    output logic [1:0]          judge_lane,
    output logic [1:0]          judge_result,
    output logic                busy,
    output logic                done
);

    localparam int TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW       = TIME_W + 1;
    localparam int LANE_LSB = lane_lsb(TIME_W);
    localparam int END_BIT  = end_bit(TIME_W);

    state_e           state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [TIME_W-1:0] song_time_q, song_time_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [31:0]       score_q, score_d;
    logic [15:0]       combo_q, combo_d;
    logic              judge_valid_q, judge_valid_d;
    logic [1:0]        judge_lane_q, judge_lane_d;
    judge_result_e     judge_result_q, judge_result_d;
    logic [3:0]        pending_q, pending_d;
    logic [1:0]        rr_q, rr_d;
    logic              fetch_wait_q, fetch_wait_d;

    logic [TIME_W-1:0] rom_time;
    logic [1:0]        rom_lane;
    logic              rom_end;
    logic [3:0]        q_push, q_pop, q_full, q_empty, expired;
    logic [TIME_W-1:0] q_head [4];
    logic              active;
    logic [EW-1:0]     now_x, head_x, delta;
    logic [2:0]        exp_pick, prs_pick;
    logic [31:0]       inc;

    assign rom_time = rom_data[TIME_LSB +: TIME_W];
    assign rom_lane = rom_data[LANE_LSB +: 2];
    assign rom_end  = rom_data[END_BIT];
    assign active   = (state_q == RUN) || (state_q == DRAIN);
    assign now_x    = {1'b0, song_time_q};

    for (genvar g = 0; g < 4; g++) begin : g_lane
        lane_queue #(.DEPTH(QDEPTH), .W(TIME_W)) u_queue (
            .clk       (clk),
            .rst       (rst),
            .push      (q_push[g]),
            .push_data (rom_time),
            .pop       (q_pop[g]),
            .head      (q_head[g]),
            .full      (q_full[g]),
            .empty     (q_empty[g])
        );
    end

    always_comb begin
        expired = '0;
        for (int i = 0; i < 4; i++) begin
            expired[i] = active && !q_empty[i] &&
                         (now_x > ({1'b0, q_head[i]} + EW'(MISS_MS)));
        end
    end

    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        song_time_d    = song_time_q;
        tick_d         = tick_q;
        score_d        = score_q;
        combo_d        = combo_q;
        pending_d      = pending_q | key_press;
        rr_d           = rr_q;
        fetch_wait_d   = 1'b0;
        judge_valid_d  = 1'b0;
        judge_lane_d   = judge_lane_q;
        judge_result_d = judge_result_q;
        q_push         = '0;
        q_pop          = '0;
        head_x         = '0;
        delta          = '0;
        inc            = '0;
        exp_pick       = rr_pick(expired, rr_q);
        prs_pick       = rr_pick(pending_q & {4{active}}, rr_q);

        // Expired notes outrank presses; a press landing on a cleared lane stays pending.
        if (exp_pick[2]) begin
            q_pop[exp_pick[1:0]] = 1'b1;
            judge_valid_d        = 1'b1;
            judge_lane_d         = exp_pick[1:0];
            judge_result_d       = MISS;
            rr_d                 = exp_pick[1:0];
        end else if (prs_pick[2]) begin
            pending_d[prs_pick[1:0]] = key_press[prs_pick[1:0]];
            rr_d                     = prs_pick[1:0];
            head_x                   = {1'b0, q_head[prs_pick[1:0]]};
            if (!q_empty[prs_pick[1:0]] && (head_x <= now_x + EW'(GOOD_MS))) begin
                q_pop[prs_pick[1:0]] = 1'b1;
                judge_valid_d        = 1'b1;
                judge_lane_d         = prs_pick[1:0];
                delta                = (now_x >= head_x) ? now_x - head_x : head_x - now_x;
                if (delta <= EW'(PERFECT_MS)) begin
                    judge_result_d = PERFECT;
                end else if (delta <= EW'(GOOD_MS)) begin
                    judge_result_d = GOOD;
                end else begin
                    judge_result_d = MISS;
                end
            end
        end

        if (judge_valid_d) begin
            if (judge_result_d == MISS) begin
                combo_d = '0;
            end else begin
                inc     = (judge_result_d == PERFECT) ? SCORE_PERFECT : SCORE_GOOD;
                score_d = (score_q > 32'hFFFF_FFFF - inc) ? 32'hFFFF_FFFF : score_q + inc;
                combo_d = (combo_q == 16'hFFFF) ? combo_q : combo_q + 16'd1;
            end
        end

        // The word after a push is still the old address's data, so skip one cycle.
        if (state_q == RUN && !fetch_wait_q) begin
            if (rom_end) begin
                state_d = DRAIN;
            end else if (({1'b0, rom_time} <= now_x + EW'(GOOD_MS)) &&
                         (!q_full[rom_lane] || q_pop[rom_lane])) begin
                q_push[rom_lane] = 1'b1;
                rom_addr_d       = rom_addr_q + ADDR_W'(1);
                fetch_wait_d     = 1'b1;
            end
        end

        if (active) begin
            if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                tick_d = '0;
                if (song_time_q != '1) begin
                    song_time_d = song_time_q + TIME_W'(1);
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = PRIME;
                    rom_addr_d  = chart_base;
                    song_time_d = '0;
                    tick_d      = '0;
                    score_d     = '0;
                    combo_d     = '0;
                    pending_d   = '0;
                    rr_d        = 2'd3;
                end
            end
            PRIME:   state_d = RUN;
            DRAIN:   if (&q_empty) state_d = DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rom_addr_q     <= '0;
            song_time_q    <= '0;
            tick_q         <= '0;
            score_q        <= '0;
            combo_q        <= '0;
            judge_valid_q  <= 1'b0;
            judge_lane_q   <= '0;
            judge_result_q <= MISS;
            pending_q      <= '0;
            rr_q           <= 2'd3;
            fetch_wait_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            song_time_q    <= song_time_d;
            tick_q         <= tick_d;
            score_q        <= score_d;
            combo_q        <= combo_d;
            judge_valid_q  <= judge_valid_d;
            judge_lane_q   <= judge_lane_d;
            judge_result_q <= judge_result_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            fetch_wait_q   <= fetch_wait_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign song_time    = song_time_q;
    assign score        = score_q;
    assign combo        = combo_q;
    assign judge_valid  = judge_valid_q;
    assign judge_lane   = judge_lane_q;
    assign judge_result = judge_result_q;
    assign busy         = (state_q == PRIME) || active;
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_chart_judge_sequencer.sv
// Directed bench for chart_judge_sequencer with a 4-cycle millisecond tick.
// A monitor logs every judgement strobe; each scenario task checks its own results.
module tb_chart_judge_sequencer;

    localparam int CLK_HZ = 4000;
    localparam logic [22:0] END_WORD = 23'h400000;
    localparam int WAIT_LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  chart_base = '0;
    logic [9:0]  rom_addr;
    logic [22:0] rom_data = '0;
    logic [3:0]  key_press = '0;
    logic [19:0] song_time;
    logic [31:0] score;
    logic [15:0] combo;
    logic        judge_valid;
    logic [1:0]  judge_lane;
    logic [1:0]  judge_result;
    logic        busy;
    logic        done;

    logic [22:0] rom [0:1023];

    int checks = 0;
    int errors = 0;

    int log_n = 0;
    int cyc = 0;
    logic [1:0]  log_lane [64];
    logic [1:0]  log_res  [64];
    logic [19:0] log_time [64];
    int          log_cyc  [64];

    chart_judge_sequencer #(.CLK_HZ(CLK_HZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .chart_base   (chart_base),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .key_press    (key_press),
        .song_time    (song_time),
        .score        (score),
        .combo        (combo),
        .judge_valid  (judge_valid),
        .judge_lane   (judge_lane),
        .judge_result (judge_result),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (judge_valid && log_n < 64) begin
            log_lane[log_n] = judge_lane;
            log_res[log_n]  = judge_result;
            log_time[log_n] = song_time;
            log_cyc[log_n]  = cyc;
            log_n = log_n + 1;
        end
    end

    function automatic logic [22:0] note(input logic [1:0] lane, input int t);
        logic [19:0] tv;
        tv = t[19:0];
        return {1'b0, lane, tv};
    endfunction

    task automatic start_song(input logic [9:0] base);
        @(negedge clk);
        chart_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask);
        key_press = mask;
        @(negedge clk);
        key_press = '0;
    endtask

    task automatic wait_time(input int target);
        int n;
        n = 0;
        while (song_time != 20'(target) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) begin
            checks++; errors++;
            $display("[TB] FAIL wait_time got %0d expected %0d", song_time, target);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) begin
            checks++; errors++;
            $display("[TB] FAIL wait_done got %0b expected 1", done);
        end
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_rom_addr got %0d expected 0", rom_addr); end
        checks++; if (song_time !== 20'd0) begin errors++; $display("[TB] FAIL reset_song_time got %0d expected 0", song_time); end
        checks++; if (score !== 32'd0) begin errors++; $display("[TB] FAIL reset_score got %0d expected 0", score); end
        checks++; if (combo !== 16'd0) begin errors++; $display("[TB] FAIL reset_combo got %0d expected 0", combo); end
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_judge_valid got %0b expected 0", judge_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done got %0b%0b expected 00", busy, done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_perfect();
        int n0;
        rom[16] = note(2'd0, 500);
        rom[17] = END_WORD;
        n0 = log_n;
        start_song(10'd16);
        checks++; if (busy !== 1'b1 || rom_addr !== 10'd16) begin errors++; $display("[TB] FAIL perfect_start got busy %0b addr %0d expected busy 1 addr 16", busy, rom_addr); end
        wait_time(520);
        press(4'b0001);
        wait_done();
        checks++; if (log_n - n0 !== 1) begin errors++; $display("[TB] FAIL perfect_count got %0d expected 1", log_n - n0); end
        checks++; if (log_res[n0] !== 2'd2 || log_lane[n0] !== 2'd0) begin errors++; $display("[TB] FAIL perfect_result got res %0d lane %0d expected res 2 lane 0", log_res[n0], log_lane[n0]); end
        checks++; if (score !== 32'd300) begin errors++; $display("[TB] FAIL perfect_score got %0d expected 300", score); end
        checks++; if (combo !== 16'd1) begin errors++; $display("[TB] FAIL perfect_combo got %0d expected 1", combo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL perfect_busy got %0b expected 0", busy); end
    endtask

    task automatic test_good_and_early();
        int n0;
        n0 = log_n;
        start_song(10'd16);
        wait_time(430);
        press(4'b0001);
        wait_done();
        checks++; if (log_n - n0 !== 1 || log_res[n0] !== 2'd1) begin errors++; $display("[TB] FAIL good_result got count %0d res %0d expected count 1 res 1", log_n - n0, log_res[n0]); end
        checks++; if (score !== 32'd100 || combo !== 16'd1) begin errors++; $display("[TB] FAIL good_score got %0d/%0d expected 100/1", score, combo); end
        n0 = log_n;
        start_song(10'd16);
        wait_time(350);
        press(4'b0001);
        repeat (20) @(negedge clk);
        checks++; if (log_n - n0 !== 0) begin errors++; $display("[TB] FAIL early_ignored got %0d strobes expected 0", log_n - n0); end
        wait_done();
        checks++; if (log_n - n0 !== 1 || log_res[n0] !== 2'd0 || log_lane[n0] !== 2'd0) begin errors++; $display("[TB] FAIL expiry_result got count %0d res %0d lane %0d expected 1 0 0", log_n - n0, log_res[n0], log_lane[n0]); end
        checks++; if (log_time[n0] !== 20'd651) begin errors++; $display("[TB] FAIL expiry_time got %0d expected 651", log_time[n0]); end
        checks++; if (combo !== 16'd0 || score !== 32'd0) begin errors++; $display("[TB] FAIL expiry_score got %0d/%0d expected 0/0", score, combo); end
    endtask

    task automatic test_stall();
        int n0;
        for (int i = 0; i < 5; i++) rom[32 + i] = note(2'd1, 1000);
        rom[37] = END_WORD;
        n0 = log_n;
        start_song(10'd32);
        wait_time(950);
        checks++; if (rom_addr !== 10'd36) begin errors++; $display("[TB] FAIL stall_addr got %0d expected 36", rom_addr); end
        checks++; if (log_n - n0 !== 0) begin errors++; $display("[TB] FAIL stall_no_judge got %0d expected 0", log_n - n0); end
        wait_time(1000);
        for (int i = 0; i < 5; i++) begin
            press(4'b0010);
            repeat (8) @(negedge clk);
        end
        wait_done();
        checks++; if (log_n - n0 !== 5) begin errors++; $display("[TB] FAIL stall_count got %0d expected 5", log_n - n0); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (log_res[n0 + i] !== 2'd2 || log_lane[n0 + i] !== 2'd1) begin errors++; $display("[TB] FAIL stall_judge%0d got res %0d lane %0d expected res 2 lane 1", i, log_res[n0 + i], log_lane[n0 + i]); end
        end
        checks++; if (score !== 32'd1500 || combo !== 16'd5) begin errors++; $display("[TB] FAIL stall_score got %0d/%0d expected 1500/5", score, combo); end
        checks++; if (rom_addr !== 10'd37) begin errors++; $display("[TB] FAIL stall_final_addr got %0d expected 37", rom_addr); end
    endtask

    task automatic test_round_robin();
        int n0;
        for (int i = 0; i < 4; i++) rom[64 + i] = note(2'(i), 200);
        rom[68] = note(2'd3, 400);
        rom[69] = END_WORD;
        n0 = log_n;
        start_song(10'd64);
        wait_time(200);
        press(4'b1111);
        repeat (10) @(negedge clk);
        checks++; if (log_n - n0 !== 4) begin errors++; $display("[TB] FAIL rr_count got %0d expected 4", log_n - n0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (log_lane[n0 + i] !== 2'(i) || log_res[n0 + i] !== 2'd2) begin errors++; $display("[TB] FAIL rr_order%0d got lane %0d res %0d expected lane %0d res 2", i, log_lane[n0 + i], log_res[n0 + i], i); end
            checks++; if (log_cyc[n0 + i] !== log_cyc[n0] + i) begin errors++; $display("[TB] FAIL rr_consecutive%0d got cycle %0d expected %0d", i, log_cyc[n0 + i], log_cyc[n0] + i); end
        end
        checks++; if (score !== 32'd1200 || combo !== 16'd4) begin errors++; $display("[TB] FAIL rr_score got %0d/%0d expected 1200/4", score, combo); end
        wait_done();
        checks++; if (log_n - n0 !== 5 || log_res[n0 + 4] !== 2'd0 || log_lane[n0 + 4] !== 2'd3) begin errors++; $display("[TB] FAIL rr_miss got count %0d res %0d lane %0d expected 5 0 3", log_n - n0, log_res[n0 + 4], log_lane[n0 + 4]); end
        checks++; if (combo !== 16'd0 || score !== 32'd1200) begin errors++; $display("[TB] FAIL rr_miss_combo got %0d/%0d expected 1200/0", score, combo); end
    endtask

    task automatic test_reset_mid_run();
        int n0;
        rom[96] = note(2'd2, 100);
        rom[97] = note(2'd2, 150);
        rom[98] = note(2'd2, 2000);
        rom[99] = END_WORD;
        start_song(10'd96);
        wait_time(100);
        press(4'b0100);
        wait_time(150);
        press(4'b0100);
        repeat (4) @(negedge clk);
        checks++; if (score !== 32'd600 || combo !== 16'd2) begin errors++; $display("[TB] FAIL midrun_score got %0d/%0d expected 600/2", score, combo); end
        rst = 1'b1;
        #1;
        checks++; if (score !== 32'd0 || combo !== 16'd0 || song_time !== 20'd0) begin errors++; $display("[TB] FAIL midrun_reset_counts got %0d/%0d/%0d expected 0/0/0", score, combo, song_time); end
        checks++; if (rom_addr !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || judge_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_ctrl got addr %0d busy %0b done %0b jv %0b expected all 0", rom_addr, busy, done, judge_valid); end
        @(negedge clk);
        rst = 1'b0;
        n0 = log_n;
        start_song(10'd96);
        checks++; if (rom_addr !== 10'd96 || busy !== 1'b1) begin errors++; $display("[TB] FAIL replay_start got addr %0d busy %0b expected 96 1", rom_addr, busy); end
        wait_time(100);
        press(4'b0100);
        repeat (4) @(negedge clk);
        checks++; if (log_n - n0 !== 1 || log_lane[n0] !== 2'd2 || log_res[n0] !== 2'd2) begin errors++; $display("[TB] FAIL replay_judge got count %0d lane %0d res %0d expected 1 2 2", log_n - n0, log_lane[n0], log_res[n0]); end
        checks++; if (score !== 32'd300 || combo !== 16'd1) begin errors++; $display("[TB] FAIL replay_score got %0d/%0d expected 300/1", score, combo); end
        hard_reset();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = END_WORD;
        test_reset();
        test_perfect();
        test_good_and_early();
        test_stall();
        test_round_robin();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chart_judge_sequencer.md
Name: chart_judge_sequencer

Overview:
- Sequences one song's note chart from a synchronous chart ROM against a millisecond song clock.
- Queues upcoming notes per lane (4 lanes: a/s/k/l) and judges lane key presses against timing windows.
- Updates score and combo, and issues a one-cycle judgement event per judged note.
- Sits between the keyboard decoder and the score/display logic; owns the chart ROM address bus.

Parameters:
- CLK_HZ, 100000000, system clock frequency; sets the 1 ms tick divider.
- ADDR_W, 10, chart ROM address width.
- TIME_W, 20, note/song time width in ms.
- PERFECT_MS, 40, |delta| at or below this is PERFECT.
- GOOD_MS, 100, |delta| at or below this is GOOD; also the fetch lookahead and early-press limit.
- MISS_MS, 150, a note is MISS once song_time > note_time + MISS_MS.
- QDEPTH, 4, per-lane pending-note queue depth.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins playback from chart_base
- chart_base  in  ADDR_W  first ROM word of the selected song
- rom_addr  out  ADDR_W  chart ROM address
- rom_data  in  TIME_W+3  {end, lane[1:0], time[TIME_W-1:0]}; valid 1 cycle after rom_addr
- key_press  in  4  per-lane one-cycle press pulses
- song_time  out  TIME_W  ms since start
- score  out  32  accumulated score
- combo  out  16  current combo
- judge_valid  out  1  one-cycle judgement strobe
- judge_lane  out  2  lane of the judgement
- judge_result  out  2  0 = MISS, 1 = GOOD, 2 = PERFECT
- busy  out  1  high from start until DONE
- done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; queues empty; pending presses cleared; tick divider 0.
- The chart is sorted by ascending time. A word with end = 1 terminates the chart; its other fields are ignored.
- States:
  - IDLE: on start, latch rom_addr = chart_base, clear song_time/score/combo, go to PRIME.
  - PRIME: one cycle for ROM latency, then RUN.
  - RUN: song_time increments every CLK_HZ/1000 cycles and saturates at all-ones. On end = 1, go to DRAIN.
  - DRAIN: same as RUN but no fetch. When all queues are empty, go to DONE.
  - DONE: start restarts via the IDLE actions. start in PRIME, RUN or DRAIN is ignored.
- Fetch (RUN only):
  - When rom_data.time <= song_time + GOOD_MS and the target lane queue is not full, push the time into that lane and increment rom_addr.
  - The data for the new address arrives next cycle, so at most one push every 2 cycles.
  - If the target lane is full, fetch stalls; other lanes keep judging.
- Pending presses: a key_press bit sets a per-lane pending flag. A press arriving while its flag is already set is merged.
- Judge arbiter: at most one judgement per cycle; strobe outputs are registered, so latency is 1 cycle from selection.
  - Priority 1, expiry: a lane whose head satisfies song_time > head + MISS_MS. Pop the head and emit MISS.
  - Priority 2, press: a lane with a pending flag. Clear the flag.
    - Empty queue, or head - song_time > GOOD_MS (too early): no judgement.
    - Otherwise d = |song_time - head|. d <= PERFECT_MS gives PERFECT; d <= GOOD_MS gives GOOD; otherwise MISS (late). Pop in every judged case.
  - Ties within a priority class go round-robin from the lane after the last one served.
- Arithmetic:
  - Compare with TIME_W+1-bit unsigned values to avoid wrap.
  - PERFECT adds 300 and GOOD adds 100 to score, saturating at 32'hFFFFFFFF.
  - PERFECT or GOOD increments combo, saturating at 16'hFFFF. MISS clears combo.
- Same-cycle push and pop on a lane are both performed, and a full queue accepts the push.

Decomposition:
- Shared package holds:
  - judge result enum: MISS = 0, GOOD = 1, PERFECT = 2;
  - state enum: IDLE, PRIME, RUN, DRAIN, DONE;
  - the score increments 300 and 100;
  - the ROM word field offsets.
- One sub-module, lane_queue: QDEPTH x TIME_W circular FIFO with push, pop, head, full and empty. Instantiate 4, one per lane.

Test Plan:
- Chart {lane0 @ 500 ms, end}, press lane0 at song_time 520 -> judge_valid once, result PERFECT, score 300, combo 1, then done.
- Same chart, press at 430 -> GOOD, score 100. Press at 350 -> ignored; the note later expires at song_time 651 -> MISS, combo 0.
- Five lane1 notes all at 1000 ms with QDEPTH 4 -> 4 queued and fetch stalls; the fifth is fetched after the first pop. No note is lost and 5 judgements result.
- All 4 lanes pressed in the same cycle with notes at the current time -> 4 PERFECT strobes on 4 consecutive cycles in round-robin order, score 1200, combo 4.
- rst asserted mid-RUN with score 600 -> all outputs 0 and IDLE immediately. A new start replays from chart_base.
- Combo preloaded near 16'hFFFF via a long chart -> it holds at 16'hFFFF. A MISS clears it to 0.
